// File: rtl/trigger_pkg.sv
// Shared types for the probe trigger engine.
// Trigger condition codes, FSM states and the latched config bundle.
package trigger_pkg;

  localparam int TB_SHIFT = 2;
  localparam int TB_CW    = TB_SHIFT * 7;

  typedef enum logic [2:0] {
    EDGE         = 3'd0,
    LONGER       = 3'd1,
    SHORTER      = 3'd2,
    WINDOW       = 3'd3,
    IDLE_TIMEOUT = 3'd4
  } trig_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } trig_state_e;

  typedef struct packed {
    logic       positive;
    logic [2:0] ttype;
    logic [4:0] stage1;
    logic [2:0] time_base;
    logic [7:0] count1;
    logic [7:0] count2;
    logic       no_edge;
    logic       dur_sel;
  } trig_cfg_t;

  function automatic logic [4:0] stage_need(input logic [4:0] n);
    return (n == 5'd0) ? 5'd1 : n;
  endfunction

endpackage

// File: rtl/trigger_timebase.sv
// Tick prescaler with period 4^time_base cycles.
// Restart zeroes the count so the first tick lands one full period later.
module trigger_timebase
  import trigger_pkg::*;
(
  input  logic       clk,
  input  logic       rst_sync,
  input  logic       restart,
  input  logic [2:0] time_base,
  output logic       tick
);

  logic [TB_CW-1:0] cnt_q, cnt_d, last;

  always_comb begin
    last = TB_CW'((32'd1 << (TB_SHIFT * 32'(time_base))) - 32'd1);
    tick = !restart && (cnt_q == last);
    cnt_d = (restart || tick) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_sync) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/trigger_engine.sv
// Probe trigger engine: sync, edge detect, duration timing, arm/fire FSM.
// Config is latched on arm and held until the next disarm/re-arm.
module trigger_engine
  import trigger_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DUR_W       = 9
) (
  input  logic       clk,
  input  logic       rst_sync,
  input  logic       probe_in,
  input  logic       cfg_enable,
  input  logic       cfg_positive,
  input  logic [2:0] cfg_type,
  input  logic [4:0] cfg_stage1_count,
  input  logic [2:0] cfg_time_base,
  input  logic [7:0] cfg_count1,
  input  logic [7:0] cfg_count2,
  input  logic       cfg_longer_no_edge,
  input  logic       cfg_trig_dur_sel,
  output logic       trigger_out,
  output logic       trig_armed,
  output logic       trig_fired,
  output logic [4:0] event_count
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_q, level_d;
  logic                   edge_q, edge_d;
  logic [DUR_W-1:0]       dur_q, dur_d;
  trig_state_e            state_q, state_d;
  trig_cfg_t              cfg_q, cfg_d;
  logic [4:0]             evt_q, evt_d;
  logic                   trig_q, trig_d;

  logic             tick, tb_restart;
  logic             active, start_e, end_e, qual;
  logic [DUR_W-1:0] c1, c2;

  assign tb_restart = edge_q || (state_q != ST_ARMED);

  trigger_timebase u_tb (
    .clk       (clk),
    .rst_sync  (rst_sync),
    .restart   (tb_restart),
    .time_base (cfg_q.time_base),
    .tick      (tick)
  );

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], probe_in};
    level_d = sync_q[SYNC_STAGES-1];
    edge_d  = sync_q[SYNC_STAGES-1] ^ level_q;
    dur_d   = dur_q;
    if (tb_restart)
      dur_d = '0;
    else if (tick && (dur_q != '1))
      dur_d = dur_q + 1'b1;
  end

  // level_q is already the post-edge level while edge_q is high
  always_comb begin
    c1      = DUR_W'(cfg_q.count1);
    c2      = DUR_W'(cfg_q.count2);
    active  = (level_q == cfg_q.positive);
    start_e = edge_q && active;
    end_e   = edge_q && !active;
    qual    = 1'b0;
    case (cfg_q.ttype)
      EDGE:    qual = start_e;
      LONGER:  qual = cfg_q.no_edge ? (tick && active && dur_q == c1)
                                    : (end_e && dur_q > c1);
      SHORTER: qual = end_e && (dur_q < c1);
      WINDOW:  qual = end_e && (c1 <= c2) && (dur_q >= c1)
                      && (dur_q <= c2);
      IDLE_TIMEOUT: qual = tick && (dur_q == c1);
      default: qual = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    evt_d   = evt_q;
    trig_d  = 1'b0;
    if (!cfg_enable) begin
      state_d = ST_IDLE;
      evt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d       = ST_ARMED;
          evt_d         = '0;
          cfg_d.positive  = cfg_positive;
          cfg_d.ttype     = cfg_type;
          cfg_d.stage1    = cfg_stage1_count;
          cfg_d.time_base = cfg_time_base;
          cfg_d.count1    = cfg_count1;
          cfg_d.count2    = cfg_count2;
          cfg_d.no_edge   = cfg_longer_no_edge;
          cfg_d.dur_sel   = cfg_trig_dur_sel;
        end
        ST_ARMED: begin
          if (qual) begin
            evt_d = (evt_q == 5'd31) ? evt_q : evt_q + 5'd1;
            if (evt_d >= stage_need(cfg_q.stage1)) begin
              state_d = ST_FIRED;
              trig_d  = 1'b1;
            end
          end
        end
        ST_FIRED: trig_d = cfg_q.dur_sel;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      edge_q  <= 1'b0;
      dur_q   <= '0;
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      evt_q   <= '0;
      trig_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      edge_q  <= edge_d;
      dur_q   <= dur_d;
      state_q <= state_d;
      cfg_q   <= cfg_d;
      evt_q   <= evt_d;
      trig_q  <= trig_d;
    end
  end

  assign trigger_out = trig_q;
  assign trig_armed  = (state_q == ST_ARMED);
  assign trig_fired  = (state_q == ST_FIRED);
  assign event_count = evt_q;

endmodule
